// File: rtl/wimax_phy_bist_ctrl.sv
// wimax_phy_bist_ctrl
// Built-in self-test sequencer for the WiMAX PHY chain (PRBS -> FEC -> interleaver ->
// modulator). It loads the PRBS seed and enables the generator. It waits for the chain
// latency to pass, then watches the four stage pass flags for a fixed window. At the end
// it holds a sticky per-stage fail vector, an overall verdict and the index of the first
// failing monitor cycle.

module wimax_phy_bist_ctrl #(
  parameter int LOAD_CYCLES    = 2,
  parameter int WARMUP_CYCLES  = 256,
  parameter int MONITOR_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk_ref,
  input  logic             reset_N,
  input  logic             start,
  input  logic             abort,
  input  logic             prbs_pass,
  input  logic             fec_pass,
  input  logic             interleaver_pass,
  input  logic             modulator_pass,
  output logic             load,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic [3:0]       fail_vec,
  output logic [CNT_W-1:0] first_fail_idx
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WARMUP,
    MONITOR,
    DONE
  } state_t;

  // Terminal counts: every phase counts 0 .. N-1 and leaves on N-1, so no phase ever wraps
  localparam logic [CNT_W-1:0] LOAD_LAST    = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WARMUP_LAST  = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] MONITOR_LAST = CNT_W'(MONITOR_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       stage_fail;
  logic [3:0]       fail_vec_next;

  // A low pass flag marks that stage as failing in this cycle; merge into the sticky vector
  always_comb begin
    stage_fail    = ~{modulator_pass, interleaver_pass, fec_pass, prbs_pass};
    fail_vec_next = fail_vec | stage_fail;
  end

  // Sequencer: a single FSM with one shared phase counter and registered outputs
  always_ff @(posedge clk_ref) begin
    if (!reset_N) begin
      state          <= IDLE;
      cnt            <= '0;
      load           <= 1'b0;
      en             <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      all_pass       <= 1'b0;
      fail_vec       <= 4'b0000;
      first_fail_idx <= '1;
    end else if (abort) begin
      state    <= IDLE;
      cnt      <= '0;
      load     <= 1'b0;
      en       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      all_pass <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= LOAD;
            cnt            <= '0;
            load           <= 1'b1;
            en             <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
            all_pass       <= 1'b0;
            fail_vec       <= 4'b0000;
            first_fail_idx <= '1;
          end
        end

        LOAD: begin
          if (cnt == LOAD_LAST) begin
            state <= WARMUP;
            cnt   <= '0;
            load  <= 1'b0;
            en    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WARMUP: begin
          if (cnt == WARMUP_LAST) begin
            state <= MONITOR;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        MONITOR: begin
          fail_vec <= fail_vec_next;
          if ((|stage_fail) && (fail_vec == 4'b0000)) begin
            first_fail_idx <= cnt;
          end
          if (cnt == MONITOR_LAST) begin
            state    <= DONE;
            cnt      <= '0;
            en       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            all_pass <= (fail_vec_next == 4'b0000);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          load  <= 1'b0;
          en    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
